// File: rtl/waveform_scroll_if.sv
// Raster position, sample stream and pixel result of the scrolling trace renderer.
// master = raster/sample source, slave = renderer.
interface waveform_scroll_if #(
    parameter int SAMPLE_W = 8
);
    logic [10:0]         hcount;
    logic [9:0]          vcount;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                freeze;
    logic [11:0]         pixel;
    logic                buffer_full;

    modport master (
        output hcount, vcount, sample_valid, sample_in, freeze,
        input  pixel, buffer_full
    );

    modport slave (
        input  hcount, vcount, sample_valid, sample_in, freeze,
        output pixel, buffer_full
    );
endinterface

// File: rtl/waveform_scroll.sv
// Scrolling oscilloscope trace: circular sample buffer drawn as a connected line, pixel 2 cycles after hcount/vcount,
// no backpressure (samples arriving while frozen are dropped). Optional grid overlay: define WAVEFORM_SCROLL_GRID_EN.
module waveform_scroll #(
    parameter int          WIDTH     = 1024,
    parameter int          X_BEGIN   = 0,
    parameter int          TOP       = 0,
    parameter int          BOTTOM    = 768,
    parameter int          THICKNESS = 3,
    parameter int          SAMPLE_W  = 8,
    parameter logic [11:0] COLOR     = 12'hF00
) (
    input logic              clock_65mhz,
    input logic              reset,
    waveform_scroll_if.slave bus
);
    localparam int          AW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int          FW   = $clog2(WIDTH + 1);
    localparam int          PW   = 11 + SAMPLE_W;
    localparam logic [11:0] W12  = 12'(WIDTH);
    localparam logic [11:0] XB12 = 12'(X_BEGIN);
    localparam logic [11:0] XE12 = 12'(X_BEGIN + WIDTH);

    logic [SAMPLE_W-1:0] r_mem [WIDTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [FW-1:0]       r_fill;
    logic [AW-1:0]       r_base;
    logic [FW-1:0]       r_vis;
    logic                r_full;

    logic                w_wr_en;
    logic                w_latch;
    logic [FW-1:0]       w_fill_nxt;

    assign w_wr_en    = bus.sample_valid && !bus.freeze && !reset;
    assign w_latch    = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
    assign w_fill_nxt = (w_wr_en && (r_fill != FW'(WIDTH))) ? r_fill + FW'(1) : r_fill;

    always_ff @(posedge clock_65mhz) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.sample_in;
        end
    end

    // base/vis snapshot at frame start keeps the whole frame on one consistent view of the buffer
    always_ff @(posedge clock_65mhz) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_base   <= '0;
            r_vis    <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_base <= r_wr_ptr;
                r_vis  <= r_fill;
            end
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == AW'(WIDTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            r_fill <= w_fill_nxt;
            r_full <= (w_fill_nxt == FW'(WIDTH));
        end
    end

    // Stage 0: column decode and buffer address; the latch cycle itself already uses the new snapshot
    logic [AW-1:0]       w_base;
    logic [FW-1:0]       w_vis;
    logic [11:0]         w_h12;
    logic                w_in_rng;
    logic [11:0]         w_col;
    logic [11:0]         w_sum;
    logic [11:0]         w_addr12;
    logic [AW-1:0]       w_addr;
    logic [11:0]         w_first;
    logic                w_live;
    logic                w_cap;
    logic [SAMPLE_W-1:0] w_rd;
    logic [PW-1:0]       w_prod;
    logic [10:0]         w_y;

    assign w_base   = w_latch ? r_wr_ptr : r_base;
    assign w_vis    = w_latch ? r_fill : r_vis;
    assign w_h12    = {1'b0, bus.hcount};
    assign w_in_rng = (w_h12 >= XB12) && (w_h12 < XE12);
    assign w_col    = w_h12 - XB12;
    assign w_sum    = 12'(w_base) + w_col;
    assign w_addr12 = (w_sum >= W12) ? (w_sum - W12) : w_sum;
    assign w_addr   = w_in_rng ? AW'(w_addr12) : '0;
    assign w_first  = W12 - 12'(w_vis);
    assign w_live   = w_in_rng && (w_col >= w_first);
    assign w_cap    = (w_col == 12'd0) || (w_col == w_first);
    assign w_rd     = r_mem[w_addr];
    assign w_prod   = PW'(BOTTOM - TOP) * PW'(w_rd);
    assign w_y      = 11'(BOTTOM) - 11'(w_prod >> SAMPLE_W);

`ifdef WAVEFORM_SCROLL_GRID_EN
    logic [5:0] w_vrow;
    logic       w_grid;
    logic       r_grid1;

    assign w_vrow = 6'({1'b0, bus.vcount} - 11'(TOP));
    assign w_grid = w_in_rng
                 && ({1'b0, bus.vcount} >= 11'(TOP)) && ({1'b0, bus.vcount} <= 11'(BOTTOM))
                 && ((w_col[5:0] == 6'd0) || (w_vrow == 6'd0));

    always_ff @(posedge clock_65mhz) begin
        if (reset) begin
            r_grid1 <= 1'b0;
        end else begin
            r_grid1 <= w_grid;
        end
    end
`endif

    // Stage 1: y of this column and of its left neighbour (the previous pixel of the raster)
    logic [10:0] r_y1;
    logic [10:0] r_yp1;
    logic        r_live1;
    logic [9:0]  r_v1;

    always_ff @(posedge clock_65mhz) begin
        if (reset) begin
            r_y1    <= '0;
            r_yp1   <= '0;
            r_live1 <= 1'b0;
            r_v1    <= '0;
        end else begin
            r_y1    <= w_y;
            r_yp1   <= w_cap ? w_y : r_y1;
            r_live1 <= w_live;
            r_v1    <= bus.vcount;
        end
    end

    // Stage 2: segment test
    logic [10:0] w_lo;
    logic [10:0] w_hi;
    logic [11:0] w_v12;
    logic        w_hit;
    logic [11:0] w_bg;
    logic [11:0] r_pixel;

    assign w_lo  = (r_y1 < r_yp1) ? r_y1 : r_yp1;
    assign w_hi  = (r_y1 < r_yp1) ? r_yp1 : r_y1;
    assign w_v12 = {2'b00, r_v1};
    assign w_hit = r_live1 && (w_v12 >= {1'b0, w_lo})
                && (w_v12 < ({1'b0, w_hi} + 12'(THICKNESS)));

`ifdef WAVEFORM_SCROLL_GRID_EN
    assign w_bg = r_grid1 ? 12'h444 : 12'h000;
`else
    assign w_bg = 12'h000;
`endif

    always_ff @(posedge clock_65mhz) begin
        if (reset) begin
            r_pixel <= 12'h000;
        end else begin
            r_pixel <= w_hit ? COLOR : w_bg;
        end
    end

    assign bus.pixel       = r_pixel;
    assign bus.buffer_full = r_full;
endmodule

// File: tb/tb_waveform_scroll.sv
// Bench for waveform_scroll: sample-history model checked against every pixel, plus hand-computed pixel expectations.
module tb_waveform_scroll;
    localparam int          W    = 8;
    localparam int          TOPP = 0;
    localparam int          BOT  = 256;
    localparam int          THK  = 1;
    localparam int          HN   = 10;
    localparam int          VN   = 260;
    localparam logic [11:0] COL  = 12'hF00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    waveform_scroll_if #(.SAMPLE_W(8)) bus ();

    waveform_scroll #(
        .WIDTH(W), .X_BEGIN(0), .TOP(TOPP), .BOTTOM(BOT),
        .THICKNESS(THK), .SAMPLE_W(8), .COLOR(COL)
    ) dut (
        .clock_65mhz(clk),
        .reset(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // model state: samples accepted since reset (newest last) and the frame's snapshot of them
    int unsigned hist[$];
    int unsigned snap[$];
    int          wcount = 0;
    bit          mfull  = 1'b0;
    bit          chk_en = 1'b0;
    logic [11:0] pe [2];
    int          ph [2];
    int          pv [2];
    logic [11:0] img [HN][VN];

    function automatic int ycalc(int s);
        return BOT - (((BOT - TOPP) * s) >> 8);
    endfunction

    function automatic logic [11:0] model_px(int h, int v);
        int n, first, y, yp, lo, hi;
        logic [11:0] bg;
        bg = 12'h000;
`ifdef WAVEFORM_SCROLL_GRID_EN
        if (h < W && v >= TOPP && v <= BOT && ((h % 64) == 0 || ((v - TOPP) % 64) == 0)) bg = 12'h444;
`endif
        if (h >= W) return 12'h000;
        n     = snap.size();
        first = W - n;
        if (h < first) return bg;
        y  = ycalc(snap[h - first]);
        yp = (h == 0 || h == first) ? y : ycalc(snap[h - first - 1]);
        lo = (y < yp) ? y : yp;
        hi = (y < yp) ? yp : y;
        return (v >= lo && v < hi + THK) ? COL : bg;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (bus.pixel !== pe[1]) begin
                bad++;
                $display("FAIL pixel h=%0d v=%0d got=%h want=%h", ph[1], pv[1], bus.pixel, pe[1]);
            end
            if (ph[1] < HN && pv[1] < VN) img[ph[1]][pv[1]] = bus.pixel;
            total++;
            if (bus.buffer_full !== mfull) begin
                bad++;
                $display("FAIL buffer_full got=%b want=%b", bus.buffer_full, mfull);
            end
        end
        pe[1] = pe[0];
        ph[1] = ph[0];
        pv[1] = pv[0];
        if (rst) begin
            hist.delete();
            snap.delete();
            wcount = 0;
            pe[0]  = 12'h000;
            pe[1]  = 12'h000;
        end else begin
            if (bus.hcount == 11'd0 && bus.vcount == 10'd0) snap = hist;
            pe[0] = model_px(int'(bus.hcount), int'(bus.vcount));
            if (bus.sample_valid && !bus.freeze) begin
                hist.push_back(int'(bus.sample_in));
                if (hist.size() > W) void'(hist.pop_front());
                if (wcount < W) wcount++;
            end
        end
        ph[0] = int'(bus.hcount);
        pv[0] = int'(bus.vcount);
        mfull = (wcount == W);
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            bus.hcount       = 11'd15;
            bus.vcount       = 10'd300;
            bus.sample_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
    endtask

    task automatic write_sample(input logic [7:0] s);
        tick();
        bus.hcount       = 11'd15;
        bus.vcount       = 10'd300;
        bus.sample_valid = 1'b1;
        bus.sample_in    = s;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic run_frame(input bit wen, input int wv, input int wh, input logic [7:0] wval);
        for (int v = 0; v < VN; v++) begin
            for (int h = 0; h < HN; h++) begin
                tick();
                bus.hcount       = 11'(h);
                bus.vcount       = 10'(v);
                bus.sample_valid = wen && (v == wv) && (h == wh);
                bus.sample_in    = wval;
            end
        end
        idle(4);
    endtask

    initial begin
        rst              = 1'b1;
        bus.hcount       = 11'd15;
        bus.vcount       = 10'd300;
        bus.sample_valid = 1'b0;
        bus.sample_in    = 8'h00;
        bus.freeze       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // reset state: blank frame, buffer not full
        run_frame(1'b0, 0, 0, 8'h00);
        check("reset_px_7_0", img[7][0], 12'h000);
        check("reset_px_7_256", img[7][256], 12'h000);
        check("reset_full", 12'(bus.buffer_full), 12'h000);

        // two mid-scale samples: only columns 6,7 live, row 128
        write_sample(8'h80);
        write_sample(8'h80);
        run_frame(1'b0, 0, 0, 8'h00);
        check("flat_6_128", img[6][128], COL);
        check("flat_7_128", img[7][128], COL);
        check("flat_7_127", img[7][127], 12'h000);
        check("flat_7_129", img[7][129], 12'h000);
        check("flat_5_128", img[5][128], 12'h000);

        // mid-frame write must not appear in the current frame
        run_frame(1'b1, 100, 3, 8'h40);
        check("tear_7_128", img[7][128], COL);
        check("tear_7_192", img[7][192], 12'h000);

        // write on the latch cycle: previous write shows now, this one next frame
        run_frame(1'b1, 0, 0, 8'h20);
        check("latch_7_150", img[7][150], COL);
        check("latch_7_224", img[7][224], 12'h000);
        check("latch_5_128", img[5][128], COL);
        check("latch_4_128", img[4][128], 12'h000);
        run_frame(1'b0, 0, 0, 8'h00);
        check("next_7_224", img[7][224], COL);
        check("next_7_191", img[7][191], 12'h000);
        check("next_7_225", img[7][225], 12'h000);

        // full-scale jump gives a connected vertical segment; first live column is capped flat
        do_reset();
        write_sample(8'h00);
        write_sample(8'hFF);
        run_frame(1'b0, 0, 0, 8'h00);
        check("seg_7_1", img[7][1], COL);
        check("seg_7_0", img[7][0], 12'h000);
        check("seg_7_256", img[7][256], COL);
        check("seg_7_257", img[7][257], 12'h000);
        check("seg_6_256", img[6][256], COL);
        check("seg_6_255", img[6][255], 12'h000);

        // wrap-around: 10 samples into 8 slots
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            write_sample(8'(i));
            @(negedge clk);
            if (i == 7) check("full_after7", 12'(bus.buffer_full), 12'h000);
            if (i == 8) check("full_after8", 12'(bus.buffer_full), 12'h001);
        end
        run_frame(1'b0, 0, 0, 8'h00);
        check("wrap_0_253", img[0][253], COL);
        check("wrap_0_252", img[0][252], 12'h000);
        check("wrap_0_254", img[0][254], 12'h000);
        check("wrap_1_252", img[1][252], COL);
        check("wrap_1_254", img[1][254], 12'h000);
        check("wrap_7_246", img[7][246], COL);
        check("wrap_7_247", img[7][247], COL);
        check("wrap_7_248", img[7][248], 12'h000);

        // freeze drops samples
        bus.freeze = 1'b1;
        repeat (5) write_sample(8'hFF);
        run_frame(1'b0, 0, 0, 8'h00);
        check("frz_7_246", img[7][246], COL);
        check("frz_7_1", img[7][1], 12'h000);
        bus.freeze = 1'b0;
        run_frame(1'b1, VN - 1, 9, 8'h40);
        check("unfrz_7_246", img[7][246], COL);
        check("unfrz_7_200", img[7][200], 12'h000);
        run_frame(1'b0, 0, 0, 8'h00);
        check("new_7_192", img[7][192], COL);
        check("new_7_200", img[7][200], COL);
        check("new_7_191", img[7][191], 12'h000);
        check("new_6_192", img[6][192], 12'h000);
        check("new_0_252", img[0][252], COL);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/waveform_scroll.md
Name: waveform_scroll

Overview:
- Scrolling oscilloscope-style trace for the XVGA display.
- Keeps the last WIDTH samples in an on-chip circular buffer: oldest sample at the left, newest at the right.
- Renders a connected trace: vertical segments join adjacent columns.
- Sits between the sample source (filtered ECG) and the pixel mux; fixed 2-cycle pixel latency, so the caller delays hsync/vsync/blank by 2 cycles.

Parameters:
- WIDTH, 1024: number of columns and buffer depth; any value from 2 to 2048.
- X_BEGIN, 0: left screen column of the trace.
- TOP, 0: screen row for full-scale sample.
- BOTTOM, 768: screen row for zero sample.
- THICKNESS, 3: trace thickness in rows.
- SAMPLE_W, 8: sample width in bits.
- COLOR, 12'hF00: trace colour.

Ports:
- clock_65mhz  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- hcount  in  11  current pixel column.
- vcount  in  10  current pixel row.
- sample_valid  in  1  one-cycle strobe; sample_in is taken on this cycle.
- sample_in  in  SAMPLE_W  unsigned sample.
- freeze  in  1  high = ignore new samples and hold the displayed trace.
- pixel  out  12  RGB444 output, 2 cycles after hcount/vcount.
- buffer_full  out  1  high once WIDTH samples have been stored since reset.

Behaviour:
- Clock and reset: one clock, clock_65mhz. Reset is synchronous and active-high.
- Reset values:
  - pixel = 12'h000, buffer_full = 0.
  - Write pointer wr_ptr = 0, fill count fill = 0, frame base = 0.
  - Buffer RAM is not cleared; fill masks stale contents.
- Write path:
  - On sample_valid && !freeze && !reset: store sample_in at wr_ptr.
  - wr_ptr increments and wraps from WIDTH-1 to 0.
  - fill increments and saturates at WIDTH.
  - buffer_full = (fill == WIDTH), registered.
  - sample_valid with freeze high is dropped, not queued.
- Frame latch (anti-tear):
  - On a cycle with hcount==0 && vcount==0, capture base = wr_ptr and vis = fill.
  - The whole frame renders from base/vis. Writes during the frame do not move the trace until the next frame.
- Column mapping:
  - c = hcount - X_BEGIN, valid when X_BEGIN <= hcount < X_BEGIN+WIDTH.
  - Buffer address = (base + c) mod WIDTH. Wrap is computed with compare/subtract, not a modulo operator; WIDTH need not be a power of 2.
  - Column c is "live" if c >= WIDTH - vis. Non-live columns draw nothing.
- Y mapping, stage 1 registered:
  - y = BOTTOM - (((BOTTOM-TOP) * s) >> SAMPLE_W).
  - The product is sized 11+SAMPLE_W bits, with no truncation before the shift.
- Pipeline:
  - Stage 0: RAM address from hcount.
  - Stage 1: RAM data to y, plus y_prev, the registered y of the previous column.
  - Stage 2: compare and drive pixel.
  - vcount and the live flag are delayed to match.
- Segment rule:
  - lo = min(y, y_prev), hi = max(y, y_prev).
  - pixel = COLOR when the column is live and lo <= vcount < hi + THICKNESS; otherwise 12'h000.
  - For the first live column, and for c == 0, y_prev = y (flat cap).
- Outside the column range pixel = 12'h000.
- Reset mid-frame: pixel returns to 0 the next cycle. The trace is blank until new samples arrive.
- Simultaneous sample write and frame latch: base captures the pre-write wr_ptr, and the new sample appears next frame.
- Simultaneous read and write of the same address: the renderer sees either value; the bench does not check this.

Optional Feature:
- Macro: WAVEFORM_SCROLL_GRID_EN.
- With it defined:
  - pixel = 12'h444 on the grid where no trace pixel is drawn.
  - Grid is every 64th column (c[5:0]==0) and every 64th row relative to TOP, within TOP..BOTTOM and the column range.
  - Trace colour has priority over grid.
  - Grid is drawn even on non-live columns.
- Without it: background is always 12'h000, and no grid logic is synthesised.

Test Plan:
- Reset with WIDTH=8, TOP=0, BOTTOM=256, THICKNESS=1 -> pixel==0 for a full frame; buffer_full==0.
- Write samples 0x80 then 0x80, then advance one frame -> only columns 6,7 are live. Rows 128..128 are lit in both columns, driven 2 cycles after hcount; columns 0..5 are dark.
- Write samples 0x00 then 0xFF (y=256, y=1) -> column 7 lights rows 1..256, i.e. a connected vertical segment; column 6 lights row 256 only.
- Write 10 samples 1..10 -> buffer_full==1 after the 8th. Columns show samples 3..10 oldest to newest; wr_ptr wrapped to 2.
- Assert freeze, pulse sample_valid with 0xFF 5 times, advance a frame -> display is unchanged. Deassert freeze and write 1 sample -> it appears at column 7 next frame, not mid-frame.
- With WAVEFORM_SCROLL_GRID_EN defined, WIDTH=128 -> (c=64, row 10) gives 12'h444; a trace pixel on c=64 gives COLOR.
